// File: rtl/ntt_stage_sched_pkg.sv
// ntt_stage_sched_pkg
// Shared definitions for the NTT stage scheduler: FSM state encoding and the
// stage-count / group-count functions of LOGN used to size the schedule.
package ntt_stage_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int STAGE_W = 4;
    localparam int DRAIN_W = 5;

    // Number of stages: radix-4 stages plus one radix-2 stage when LOGN is odd.
    function automatic int num_stages(input int logn);
        return (logn + 1) / 2;
    endfunction

    // Butterfly groups per stage (N/4).
    function automatic int num_groups(input int logn);
        return (1 << logn) / 4;
    endfunction

    function automatic bit has_radix2(input int logn);
        return (logn % 2) == 1;
    endfunction

endpackage

// File: rtl/ntt_stage_sched_delay_line.sv
// delay_line
// DEPTH-stage shift line of WIDTH-bit words. Shifts only when en=1, so the
// output is the input from exactly DEPTH enabled cycles earlier.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage
//   en   - shift enable; 0 holds the contents
//   din  - word entering the line
//   dout - word leaving the line
module delay_line
    import ntt_stage_sched_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched
// Address scheduler for an in-place radix-4 NTT (with a final radix-2 stage
// when LOGN is odd). Issues one group of four read addresses per enabled
// cycle, drains the butterfly pipeline between stages, and replays the read
// addresses DELAY enabled cycles later as write-back addresses.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - one-cycle transform request (ignored while busy or en=0)
//   en                  - global advance enable; 0 freezes everything
//   rd_addr0..3/rd_valid - read addresses of the current group
//   wr_addr0..3/wr_valid - write-back addresses (reads delayed by DELAY)
//   stage, radix2, bfly - current stage index, radix-2 flag, group index
//   busy, done          - transform in progress, one-cycle completion pulse
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | issuing groups b = 0..N/4-1 of the current stage
// ST_DRAIN | DELAY cycles for the last write-back of the stage
// ST_DONE  | one-cycle completion, back to idle
module ntt_stage_sched
    import ntt_stage_sched_pkg::*;
#(
    parameter int LOGN  = 7,
    parameter int DELAY = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    output logic [LOGN-1:0]    rd_addr0,
    output logic [LOGN-1:0]    rd_addr1,
    output logic [LOGN-1:0]    rd_addr2,
    output logic [LOGN-1:0]    rd_addr3,
    output logic               rd_valid,
    output logic [LOGN-1:0]    wr_addr0,
    output logic [LOGN-1:0]    wr_addr1,
    output logic [LOGN-1:0]    wr_addr2,
    output logic [LOGN-1:0]    wr_addr3,
    output logic               wr_valid,
    output logic [STAGE_W-1:0] stage,
    output logic               radix2,
    output logic [LOGN-3:0]    bfly,
    output logic               busy,
    output logic               done
);

    localparam int NUM_STAGES = num_stages(LOGN);
    localparam int NUM_GROUPS = num_groups(LOGN);
    localparam int BW         = LOGN - 2;
    localparam int LINE_W     = 4 * LOGN + 1;

    localparam logic [BW-1:0]      LAST_B     = BW'(NUM_GROUPS - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DELAY - 1);
    localparam bit                 ODD_LOGN   = has_radix2(LOGN);

    state_t               state_q;
    state_t               state_d;
    logic [STAGE_W-1:0]   stage_q;
    logic [BW-1:0]        bfly_q;
    logic [DRAIN_W-1:0]   drain_q;

    logic                 last_group;
    logic                 last_stage;
    logic                 drain_tc;
    logic                 issue;
    logic                 busy_c;
    logic                 done_c;
    logic                 is_r2;

    logic [4:0]           sh;
    logic [LOGN-1:0]      b_ext;
    logic [LOGN-1:0]      mask_hi;
    logic [LOGN-1:0]      base;
    logic [1:0]           mm;
    logic [LOGN-1:0]      rd_addr_a [4];

    logic [LINE_W-1:0]    line_in;
    logic [LINE_W-1:0]    line_out;

    assign last_group = (bfly_q == LAST_B);
    assign last_stage = (stage_q == LAST_STAGE);
    assign drain_tc   = (drain_q == '0);
    assign is_r2      = ODD_LOGN && last_stage;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (last_group) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_tc) state_d = last_stage ? ST_DONE : ST_RUN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue  = 1'b0;
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                issue  = 1'b1;
                busy_c = 1'b1;
            end
            ST_DRAIN: busy_c = 1'b1;
            ST_DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- stage / group / drain counters ----------------
    // stage and bfly keep their last values through DRAIN and DONE and are
    // cleared on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            bfly_q  <= '0;
            drain_q <= '0;
        end else if (en) begin
            case (state_q)
                ST_RUN: begin
                    if (last_group) begin
                        drain_q <= DRAIN_LOAD;
                    end else begin
                        bfly_q <= bfly_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_tc) begin
                        drain_q <= drain_q - 1'b1;
                    end else if (!last_stage) begin
                        stage_q <= stage_q + 1'b1;
                        bfly_q  <= '0;
                    end
                end
                ST_DONE: begin
                    stage_q <= '0;
                    bfly_q  <= '0;
                    drain_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- address generation ----------------
    // Radix-4 stage s: d = 4^s. Since low = b mod d fits below bit 2s, the
    // base is b with its bits at and above 2s moved up by two, and m*d lands
    // in the two freed bits, so the adds reduce to ORs.
    // Radix-2 stage: the two freed top bits select b, b+N/2, b+N/4, b+3N/4,
    // i.e. the top two bits are m bit-reversed.
    always_comb begin
        sh      = {stage_q, 1'b0};
        b_ext   = {2'b00, bfly_q};
        mask_hi = {LOGN{1'b1}} << sh;
        base    = ((b_ext & mask_hi) << 2) | (b_ext & ~mask_hi);
        mm      = 2'b00;
        for (int m = 0; m < 4; m++) begin
            mm = 2'(m);
            if (!issue) begin
                rd_addr_a[m] = '0;
            end else if (is_r2) begin
                rd_addr_a[m] = {mm[0], mm[1], bfly_q};
            end else begin
                rd_addr_a[m] = base | (LOGN'(m) << sh);
            end
        end
    end

    // ---------------- write-back delay line ----------------
    // The valid bit travels unmasked by en; en only gates the outputs, and
    // the line itself holds while en=0.
    assign line_in = {issue, rd_addr_a[3], rd_addr_a[2], rd_addr_a[1], rd_addr_a[0]};

    delay_line #(
        .WIDTH (LINE_W),
        .DEPTH (DELAY)
    ) u_delay_line (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (line_in),
        .dout (line_out)
    );

    // ---------------- outputs ----------------
    // rst forces every output low in the same cycle, ahead of the
    // registered state catching up at the next edge.
    assign rd_valid = issue & en & ~rst;
    assign rd_addr0 = rst ? '0 : rd_addr_a[0];
    assign rd_addr1 = rst ? '0 : rd_addr_a[1];
    assign rd_addr2 = rst ? '0 : rd_addr_a[2];
    assign rd_addr3 = rst ? '0 : rd_addr_a[3];

    assign wr_valid = line_out[LINE_W-1] & en & ~rst;
    assign wr_addr0 = rst ? '0 : line_out[LOGN-1:0];
    assign wr_addr1 = rst ? '0 : line_out[2*LOGN-1:LOGN];
    assign wr_addr2 = rst ? '0 : line_out[3*LOGN-1:2*LOGN];
    assign wr_addr3 = rst ? '0 : line_out[4*LOGN-1:3*LOGN];

    assign stage  = (busy_c && !rst) ? stage_q : '0;
    assign bfly   = (busy_c && !rst) ? bfly_q : '0;
    assign radix2 = busy_c & is_r2 & ~rst;
    assign busy   = busy_c & ~rst;
    assign done   = done_c & en & ~rst;

endmodule

// File: tb/tb_ntt_stage_sched.sv
module tb_ntt_stage_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic start, en, rst_a, rst_b;
    int   sel;
    int   checks = 0;
    int   errors = 0;

    // DUT A: LOGN=7, DELAY=13
    logic [6:0] a_rd0, a_rd1, a_rd2, a_rd3, a_wr0, a_wr1, a_wr2, a_wr3;
    logic       a_rdv, a_wrv, a_r2, a_busy, a_done;
    logic [3:0] a_stage;
    logic [4:0] a_bfly;

    // DUT B: LOGN=6, DELAY=4
    logic [5:0] b_rd0, b_rd1, b_rd2, b_rd3, b_wr0, b_wr1, b_wr2, b_wr3;
    logic       b_rdv, b_wrv, b_r2, b_busy, b_done;
    logic [3:0] b_stage;
    logic [3:0] b_bfly;

    ntt_stage_sched #(.LOGN(7), .DELAY(13)) dut_a (
        .clk(clk), .rst(rst_a), .start(start), .en(en),
        .rd_addr0(a_rd0), .rd_addr1(a_rd1), .rd_addr2(a_rd2), .rd_addr3(a_rd3),
        .rd_valid(a_rdv),
        .wr_addr0(a_wr0), .wr_addr1(a_wr1), .wr_addr2(a_wr2), .wr_addr3(a_wr3),
        .wr_valid(a_wrv),
        .stage(a_stage), .radix2(a_r2), .bfly(a_bfly), .busy(a_busy), .done(a_done)
    );

    ntt_stage_sched #(.LOGN(6), .DELAY(4)) dut_b (
        .clk(clk), .rst(rst_b), .start(start), .en(en),
        .rd_addr0(b_rd0), .rd_addr1(b_rd1), .rd_addr2(b_rd2), .rd_addr3(b_rd3),
        .rd_valid(b_rdv),
        .wr_addr0(b_wr0), .wr_addr1(b_wr1), .wr_addr2(b_wr2), .wr_addr3(b_wr3),
        .wr_valid(b_wrv),
        .stage(b_stage), .radix2(b_r2), .bfly(b_bfly), .busy(b_busy), .done(b_done)
    );

    // Observation bus for whichever DUT is selected.
    logic [11:0] o_rd [4];
    logic [11:0] o_wr [4];
    logic        o_rdv, o_wrv, o_r2, o_busy, o_done;
    logic [3:0]  o_stage;
    logic [9:0]  o_bfly;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            o_rd[i] = '0;
            o_wr[i] = '0;
        end
        o_rdv = 1'b0; o_wrv = 1'b0; o_r2 = 1'b0; o_busy = 1'b0; o_done = 1'b0;
        o_stage = '0; o_bfly = '0;
        if (sel == 0) begin
            o_rd[0] = 12'(a_rd0); o_rd[1] = 12'(a_rd1); o_rd[2] = 12'(a_rd2); o_rd[3] = 12'(a_rd3);
            o_wr[0] = 12'(a_wr0); o_wr[1] = 12'(a_wr1); o_wr[2] = 12'(a_wr2); o_wr[3] = 12'(a_wr3);
            o_rdv = a_rdv; o_wrv = a_wrv; o_r2 = a_r2; o_busy = a_busy; o_done = a_done;
            o_stage = a_stage; o_bfly = 10'(a_bfly);
        end else begin
            o_rd[0] = 12'(b_rd0); o_rd[1] = 12'(b_rd1); o_rd[2] = 12'(b_rd2); o_rd[3] = 12'(b_rd3);
            o_wr[0] = 12'(b_wr0); o_wr[1] = 12'(b_wr1); o_wr[2] = 12'(b_wr2); o_wr[3] = 12'(b_wr3);
            o_rdv = b_rdv; o_wrv = b_wrv; o_r2 = b_r2; o_busy = b_busy; o_done = b_done;
            o_stage = b_stage; o_bfly = 10'(b_bfly);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_rst(input logic v);
        if (sel == 0) rst_a = v;
        else rst_b = v;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int m = 0; m < 4; m++) begin
            chk({tag, "_rd_addr"}, 32'(o_rd[m]), 32'd0);
            chk({tag, "_wr_addr"}, 32'(o_wr[m]), 32'd0);
        end
        chk({tag, "_rd_valid"}, 32'(o_rdv), 32'd0);
        chk({tag, "_wr_valid"}, 32'(o_wrv), 32'd0);
        chk({tag, "_stage"},    32'(o_stage), 32'd0);
        chk({tag, "_radix2"},   32'(o_r2), 32'd0);
        chk({tag, "_bfly"},     32'(o_bfly), 32'd0);
        chk({tag, "_busy"},     32'(o_busy), 32'd0);
        chk({tag, "_done"},     32'(o_done), 32'd0);
    endtask

    task automatic chk_grp(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_0"}, 32'(o_rd[0]), 32'(e0));
        chk({tag, "_1"}, 32'(o_rd[1]), 32'(e1));
        chk({tag, "_2"}, 32'(o_rd[2]), 32'(e2));
        chk({tag, "_3"}, 32'(o_rd[3]), 32'(e3));
    endtask

    // Reference: address m of group b in stage s, straight from the
    // transform's definition.
    function automatic int addr_of(input int logn, input int s, input int b, input int m);
        int n;
        int d;
        n = 1 << logn;
        if ((logn % 2) == 1 && s == (logn + 1) / 2 - 1) begin
            case (m)
                0:       return b;
                1:       return b + n / 2;
                2:       return b + n / 4;
                default: return b + 3 * n / 4;
            endcase
        end
        d = 1;
        for (int i = 0; i < s; i++) d = d * 4;
        return (b / d) * 4 * d + (b % d) + m * d;
    endfunction

    // Reference timeline: what the schedule shows k enabled cycles after
    // the cycle that sampled start.
    function automatic void model(input int logn, input int delay, input int k,
                                  output bit v, output int st, output int b,
                                  output bit r2, output bit bsy, output bit dn);
        int g, ns, p, j;
        g  = (1 << logn) / 4;
        ns = (logn + 1) / 2;
        p  = g + delay;
        v = 0; st = 0; b = 0; r2 = 0; bsy = 0; dn = 0;
        if (k >= 1 && k <= ns * p) begin
            bsy = 1;
            st  = (k - 1) / p;
            j   = (k - 1) % p;
            r2  = ((logn % 2) == 1) && (st == ns - 1);
            if (j < g) begin
                v = 1;
                b = j;
            end else begin
                b = g - 1;
            end
        end else if (k == ns * p + 1) begin
            bsy = 1;
            dn  = 1;
        end
    endfunction

    task automatic run_xfer(input int logn, input int delay, input int pause_at, input int pause_len,
                            input bit rand_en, input bit junk_start, input int abort_at,
                            output int done_cyc);
        int  g, ns, p, last_k, k, cyc;
        bit  v, r2, bsy, dn, wv, w_r2, w_bsy, w_dn;
        int  st, b, w_st, w_b;
        g      = (1 << logn) / 4;
        ns     = (logn + 1) / 2;
        p      = g + delay;
        last_k = ns * p + 1;
        done_cyc = -1;

        start = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        chk("pre_start_busy",  32'(o_busy), 32'd0);
        chk("pre_start_stage", 32'(o_stage), 32'd0);
        chk("pre_start_bfly",  32'(o_bfly), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;

        k   = 1;
        cyc = 1;
        while (k <= last_k && cyc < 4000) begin
            en = 1'b1;
            if (cyc >= pause_at && cyc < pause_at + pause_len) en = 1'b0;
            else if (rand_en && $urandom_range(0, 3) == 0) en = 1'b0;
            start = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;

            if (cyc == abort_at) begin
                set_rst(1'b1);
                @(negedge clk);
                chk_all_zero("abort_rst");
                @(posedge clk); #1;
                set_rst(1'b0);
                start = 1'b0;
                en    = 1'b1;
                @(negedge clk);
                chk_all_zero("abort_next");
                for (int i = 0; i < delay + 20; i++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("abort_wr_valid", 32'(o_wrv), 32'd0);
                    chk("abort_done",     32'(o_done), 32'd0);
                    chk("abort_busy",     32'(o_busy), 32'd0);
                end
                @(posedge clk); #1;
                return;
            end

            model(logn, delay, k, v, st, b, r2, bsy, dn);
            model(logn, delay, k - delay, wv, w_st, w_b, w_r2, w_bsy, w_dn);
            @(negedge clk);
            chk("busy",     32'(o_busy), 32'(bsy));
            chk("done",     32'(o_done), 32'(dn & en));
            chk("rd_valid", 32'(o_rdv), 32'(v & en));
            chk("wr_valid", 32'(o_wrv), 32'(wv & en));
            if (!dn) begin
                chk("stage",  32'(o_stage), 32'(st));
                chk("radix2", 32'(o_r2), 32'(r2));
                chk("bfly",   32'(o_bfly), 32'(b));
            end
            if (v) begin
                for (int m = 0; m < 4; m++) chk("rd_addr", 32'(o_rd[m]), 32'(addr_of(logn, st, b, m)));
            end
            if (wv) begin
                for (int m = 0; m < 4; m++) chk("wr_addr", 32'(o_wr[m]), 32'(addr_of(logn, w_st, w_b, m)));
            end
            if (logn == 7 && v && st == 0 && b == 5) chk_grp("s0_b5", 20, 21, 22, 23);
            if (logn == 7 && v && st == 1 && b == 5) chk_grp("s1_b5", 17, 21, 25, 29);
            if (logn == 7 && v && st == 3 && b == 3) begin
                chk_grp("s3_b3", 3, 67, 35, 99);
                chk("s3_b3_radix2", 32'(o_r2), 32'd1);
            end
            if (logn == 6 && v && st == 2 && b == 15) chk_grp("l6_s2_b15", 15, 31, 47, 63);
            if (dn && en) done_cyc = cyc;

            @(posedge clk); #1;
            if (en) k++;
            cyc++;
        end
        chk("run_completed", 32'(k), 32'(last_k + 1));
        start = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        chk("post_busy", 32'(o_busy), 32'd0);
        chk("post_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;
    endtask

    int dc;

    initial begin
        sel   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        start = 1'b1;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_a = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("after_reset_busy", 32'(o_busy), 32'd0);

        // start while en=0 in IDLE must not launch
        @(posedge clk); #1;
        start = 1'b1;
        en    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        en    = 1'b1;
        @(negedge clk);
        chk("start_en0_busy", 32'(o_busy), 32'd0);
        @(posedge clk); #1;

        run_xfer(7, 13, -1, 0, 1'b0, 1'b0, -1, dc);
        chk("done_cycle_l7", 32'(dc), 32'd181);

        run_xfer(7, 13, 20, 10, 1'b0, 1'b0, -1, dc);
        chk("done_cycle_l7_pause", 32'(dc), 32'd191);

        run_xfer(7, 13, -1, 0, 1'b1, 1'b1, -1, dc);

        run_xfer(7, 13, -1, 0, 1'b0, 1'b1, 50, dc);

        run_xfer(7, 13, -1, 0, 1'b1, 1'b0, -1, dc);

        // switch to the LOGN=6 instance
        rst_a = 1'b1;
        sel   = 1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;

        run_xfer(6, 4, -1, 0, 1'b0, 1'b0, -1, dc);
        chk("done_cycle_l6", 32'(dc), 32'd61);

        run_xfer(6, 4, -1, 0, 1'b1, 1'b1, -1, dc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_stage_sched.md
NTT_STAGE_SCHED -- requirements
Module: ntt_stage_sched

Interface
REQ-001 The block SHALL have parameter LOGN, default 7, meaning log2 of transform length N (legal 4..12).
REQ-002 The block SHALL have parameter DELAY, default 13, meaning read-to-write-back latency in cycles (legal 1..31).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a full transform.
REQ-006 The block SHALL have port en, input, 1, global advance enable; 0 freezes all state.
REQ-007 The block SHALL have ports rd_addr0..rd_addr3, output, LOGN each, the four read addresses of the current butterfly group.
REQ-008 The block SHALL have port rd_valid, output, 1, which qualifies rd_addr0..3.
REQ-009 The block SHALL have ports wr_addr0..wr_addr3, output, LOGN each, write-back addresses (read addresses delayed by DELAY).
REQ-010 The block SHALL have port wr_valid, output, 1, which qualifies wr_addr0..3.
REQ-011 The block SHALL have port stage, output, 4, the index of the stage being issued.
REQ-012 The block SHALL have port radix2, output, 1, high while the final radix-2 stage issues.
REQ-013 The block SHALL have port bfly, output, LOGN-2, the butterfly-group index b (feeds twiddle addressing).
REQ-014 The block SHALL have ports busy, output, 1, and done, output, 1 (one-cycle completion pulse).

Function
REQ-015 The block SHALL run S = ceil(LOGN/2) stages; stages 0..floor(LOGN/2)-1 are radix-4, and when LOGN is odd the last stage is radix-2.
REQ-016 Each stage SHALL issue N/4 groups, b = 0..N/4-1, one group per enabled cycle, with rd_valid=1.
REQ-017 A radix-4 stage s SHALL use d=4^s, low=b mod d, high=b div d, base=high*4d+low, and rd_addrm = base+m*d for m=0..3.
REQ-018 The radix-2 stage SHALL issue rd_addr0=b, rd_addr1=b+N/2, rd_addr2=b+N/4, rd_addr3=b+3N/4, i.e. two pairs of distance N/2.
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
- IDLE: start=1 -> RUN.
- RUN: after group N/4-1 -> DRAIN.
- DRAIN: DELAY cycles, then RUN for the next stage, or DONE after the last stage.
- DONE: one cycle -> IDLE.
REQ-020 The first group SHALL issue in the cycle after start is sampled.
REQ-021 Reads of stage s+1 SHALL NOT issue until the last write of stage s has been presented.
REQ-022 wr_valid and wr_addr0..3 SHALL equal rd_valid and rd_addr0..3 from exactly DELAY enabled cycles earlier, using a DELAY-deep valid+address shift line.
REQ-023 done SHALL be 1 only in the DONE cycle, which is S*(N/4+DELAY)+1 enabled cycles after start (181 for LOGN=7, DELAY=13).
REQ-024 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-025 start SHALL be ignored when busy=1.
REQ-026 When en=0, the FSM, counters and shift line SHALL hold, and rd_valid and wr_valid SHALL be forced to 0; state resumes unchanged when en returns to 1.
REQ-027 start with en=0 in IDLE SHALL be ignored.
REQ-028 stage, radix2 and bfly SHALL be held at their last values during DRAIN, and SHALL be 0 in IDLE.

Reset
REQ-029 While rst=1, the FSM SHALL go to IDLE, all counters and shift-line valid bits SHALL clear, and every output SHALL be 0; rst takes priority over en and start.
REQ-030 Reset asserted mid-transform SHALL abort the transform with no further wr_valid and no done.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration and the stage-count and group-count functions of LOGN.
REQ-032 The delay line SHALL be one sub-module, delay_line (parameters WIDTH and DEPTH, with enable and synchronous reset), instantiated once with WIDTH 4*LOGN+1.

Verification
REQ-033 With LOGN=7, stage 0, b=5, the block SHALL issue rd_addr = 20,21,22,23.
REQ-034 With LOGN=7, stage 1, b=5, the block SHALL issue rd_addr = 17,21,25,29.
REQ-035 With LOGN=7, stage 3, b=3, the block SHALL assert radix2=1 and issue rd_addr = 3,67,35,99.
REQ-036 With LOGN=6, DELAY=4, a full run SHALL give 3 stages with radix2 never asserted, stage 2, b=15 issuing 15,31,47,63, and done at cycle 61.
REQ-037 With LOGN=7, en held 0 for 10 cycles mid-RUN, done SHALL arrive at cycle 191, and the wr_addr sequence SHALL be unchanged from an uninterrupted run.
REQ-038 A second start during RUN SHALL be ignored, and rst at cycle 50 SHALL give all outputs 0 next cycle, with no done.
